// File: rtl/data_ram_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | data_ram_arbiter_pkg : shared widths and master indices           |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package data_ram_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_NONE   = 2'd0,
    ARB_GNT_M0 = 2'd1,
    ARB_GNT_M1 = 2'd2
  } arb_sel_e;

  function automatic arb_sel_e arb_other(input logic last);
    return (last == ARB_M1) ? ARB_GNT_M0 : ARB_GNT_M1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_arbiter_if.sv
// +------------------------------------------------------------------+
// | data_ram_arbiter_if : one master request/response port            |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface data_ram_arbiter_if;
  import data_ram_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);

endinterface

`default_nettype wire

// File: rtl/data_ram_arb_starve_cnt.sv
// +------------------------------------------------------------------+
// | data_ram_arb_starve_cnt : saturating master-0 wait counter        |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module data_ram_arb_starve_cnt #(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && (cnt_q != WAIT_MAX_C)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == WAIT_MAX_C);

endmodule

`default_nettype wire

// File: rtl/data_ram_arbiter.sv
// +------------------------------------------------------------------+
// | data_ram_arbiter : two-master round-robin arbiter for data RAM    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int WAIT_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_arbiter_if.slave   m0,
  data_ram_arbiter_if.slave   m1,
  input  logic                m1_lock,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [BE_W-1:0]     ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  arb_sel_e sel;
  logic     starve_sat;
  logic     winner;
  logic     last_q, owner_q, pend_q, pend_we_q;

  always_comb begin
    sel = ARB_NONE;
    if (!rst) begin
      if (m0.req && !m1.req) begin
        sel = ARB_GNT_M0;
      end else if (m1.req && !m0.req) begin
        sel = ARB_GNT_M1;
      end else if (m0.req && m1.req) begin
        if (starve_sat) begin
          sel = ARB_GNT_M0;
        end else if (m1_lock && (last_q == ARB_M1)) begin
          sel = ARB_GNT_M1;
        end else begin
          sel = arb_other(last_q);
        end
      end
    end
  end

  assign m0.gnt = (sel == ARB_GNT_M0);
  assign m1.gnt = (sel == ARB_GNT_M1);
  assign winner = (sel == ARB_GNT_M1) ? ARB_M1 : ARB_M0;

  // RAM fields are zero whenever nobody is granted, so reset leaves them quiet.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_be    = '0;
    ram_wdata = '0;
    if (sel == ARB_GNT_M0) begin
      ram_ce    = 1'b1;
      ram_we    = m0.we;
      ram_addr  = m0.addr[RAM_AW+1:2];
      ram_be    = m0.be;
      ram_wdata = m0.wdata;
    end else if (sel == ARB_GNT_M1) begin
      ram_ce    = 1'b1;
      ram_we    = m1.we;
      ram_addr  = m1.addr[RAM_AW+1:2];
      ram_be    = m1.be;
      ram_wdata = m1.wdata;
    end
  end

  data_ram_arb_starve_cnt #(
    .WAIT_MAX (WAIT_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr_i (m0.gnt | ~m0.req),
    .inc_i (m0.req & ~m0.gnt),
    .sat_o (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= ARB_M1;
      owner_q   <= ARB_M0;
      pend_q    <= 1'b0;
      pend_we_q <= 1'b0;
    end else begin
      pend_q <= ram_ce;
      if (ram_ce) begin
        last_q    <= winner;
        owner_q   <= winner;
        pend_we_q <= ram_we;
      end
    end
  end

  // A response due in a reset cycle is suppressed rather than delivered.
  assign m0.rvalid = pend_q && (owner_q == ARB_M0) && !rst;
  assign m1.rvalid = pend_q && (owner_q == ARB_M1) && !rst;
  assign m0.rdata  = (m0.rvalid && !pend_we_q) ? ram_rdata : '0;
  assign m1.rdata  = (m1.rvalid && !pend_we_q) ? ram_rdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0.addr[31:RAM_AW+2], m0.addr[1:0],
                              m1.addr[31:RAM_AW+2], m1.addr[1:0]};

endmodule

`default_nettype wire

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-master arbiter that shares the SOPC data RAM (four byte-lane banks, 1-cycle synchronous read) between the core's load/store port (master 0) and a debug/loader port (master 1, used to preload or inspect data memory). Sits between `bitty_riscv`/loader and `data_ram`. Provides round-robin fairness, a burst lock for master 1, and a starvation guard for master 0. Accepts one access per cycle; each response is returned exactly one cycle after its grant.

## Interface
Parameters:
- `RAM_AW`, 12, data RAM word-address width (RAM depth = 2^RAM_AW words).
- `WAIT_MAX`, 8, consecutive master-0 wait cycles after which master 0 overrides a master-1 lock (range 1..255).

Ports (`mN` = `m0`, `m1`):
- `clk` in 1: single clock; everything is registered on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `mN_req` in 1: access request; fields stay stable until granted.
- `mN_we` in 1: 1 = write, 0 = read.
- `mN_addr` in 32: byte address; bits [RAM_AW+1:2] are used.
- `mN_wdata` in 32: write data.
- `mN_be` in 4: byte enables, bit i = byte lane i.
- `mN_gnt` out 1: request accepted this cycle.
- `mN_rvalid` out 1: one-cycle response pulse (read data or write ack).
- `mN_rdata` out 32: read data, valid with `mN_rvalid`; 0 for write acks.
- `m1_lock` in 1: master 1 asks to keep ownership across consecutive requests.
- `ram_ce` out 1: RAM access strobe.
- `ram_we` out 1: RAM write.
- `ram_addr` out RAM_AW: word address.
- `ram_be` out 4: byte-lane enables.
- `ram_wdata` out 32: write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after `ram_ce`.

## Operation
- Grant is combinational from the requests and registered state. At most one of `m0_gnt`/`m1_gnt` is high in any cycle. `ram_*` mirror the winner's fields in the grant cycle. `ram_ce` = `m0_gnt | m1_gnt`.
- Arbitration, in priority order:
  1. Only one master requests → that master wins.
  2. Both request and `starve == WAIT_MAX` → m0 wins.
  3. Both request, `m1_lock`=1 and `last` = m1 → m1 wins.
  4. Otherwise the master other than `last` wins (round-robin).
- `last` register: updated to the winner on every grant. Reset value = m1, so m0 wins the first contention.
- `starve` counter (8 bit):
  - Cleared on `m0_gnt` or when `m0_req`=0.
  - Incremented when `m0_req`=1 and no m0 grant.
  - Saturates at WAIT_MAX.
- Response pipeline registers:
  - `owner` (1 bit), `pend` (1 bit), `pend_we` capture the grant.
  - Next cycle: `mN_rvalid` = `pend & owner==N`.
  - `mN_rdata` = `ram_rdata` for reads, 0 for writes; non-owner `rdata` = 0.
- Back-to-back: a grant may occur in the same cycle as the previous access's response. Full throughput is 1 access/cycle.
- Writes with `be`=0: still granted and acked; no RAM bytes change.

## Timing
- Reset values: `mN_gnt`=0, `mN_rvalid`=0, `mN_rdata`=0, `ram_ce`=0, `ram_we`=0, `ram_be`=0, `ram_addr`=0, `ram_wdata`=0, `last`=m1, `starve`=0, `pend`=0.
- While `rst`=1, all grants and `ram_ce` are forced to 0.
- Latency: request seen at cycle N with no contention → `gnt` at N → `rvalid`/`rdata` at N+1.
- Reset mid-operation: a pending response is dropped (no `rvalid` in the cycle after `rst`). The RAM contents written before reset are kept.
- Simultaneous requests on the starvation cycle: m0 wins even with m1 holding the lock; `starve` clears the same edge.
- Deasserting `m1_lock` takes effect in the same cycle (rule 4 applies).
- A master whose `req` drops before grant is not serviced; requests are not queued.

## Structure
- Shared defines/package holds `DATA_W`=32, `BE_W`=4, and the master-index constants `ARB_M0`=0 and `ARB_M1`=1, reused by the SOPC top and the loader.
- One natural sub-module: `data_ram_arb_starve_cnt`, the saturating wait counter with clear/inc/sat outputs.
- The grant logic, the `last`/`owner` registers and the response demux stay in the top module.

## Test plan
1. Reset 3 cycles, then m0 writes `0xDEADBEEF`, be=`4'hF`, addr `0x10`; m0 then reads addr `0x10` → `m0_gnt` in the request cycle, `m0_rvalid` 1 cycle later with `m0_rdata`=`0xDEADBEEF`; `m1_rvalid` stays 0.
2. Byte-lane write: preload `0x11223344` at addr `0x20`, write `0x000000AA` with be=`4'b0001`, read back → `0x112233AA`.
3. Both masters request reads every cycle for 6 cycles, no lock → grants alternate m0,m1,m0,…; each `rvalid` goes to the correct master 1 cycle after its grant.
4. `m1_lock`=1 with m1 and m0 both requesting continuously, WAIT_MAX=8 → m1 is granted 8 consecutive cycles, then m0 is granted in the 9th contention cycle, then m1 resumes.
5. Assert `rst` in the cycle after an m1 read grant → no `m1_rvalid` follows; all outputs are 0 during reset; after release, m0 wins the first contention.
6. Random mixed traffic for 2000 cycles against a byte-lane reference model → all read data matches; never two grants in one cycle; exactly one `rvalid` per grant.
